// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one unified instruction/data memory between the
// multicycle CPU (port C) and the loader/debug port (port L), with bounded loader bursts.
module mem_port_arbiter #(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_stall,
    output logic [DW-1:0] c_rdata,
    input  logic          l_req,
    input  logic          l_we,
    input  logic          l_lock,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic          l_gnt,
    output logic [DW-1:0] l_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    owner,
    output logic [CW-1:0] c_wait_cnt
);

    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_LDR  = 2'b10
    } owner_t;

    owner_t        owner_q;
    logic          last_l;      // 1: loader won the most recent grant
    logic          last_valid;  // a grant has happened since reset
    logic [BW-1:0] bcnt;
    logic          contested;
    logic          burst_go;

    assign contested = c_req & l_req;
    // A burst can only continue from a real loader grant, so the first tie
    // after reset goes to the CPU even though last_l resets to 1.
    assign burst_go  = l_lock & last_l & last_valid & (bcnt < BW'(MAX_BURST));

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        c_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!rst) begin
            if (contested) begin
                if (burst_go)    l_gnt = 1'b1;
                else if (last_l) c_gnt = 1'b1;
                else             l_gnt = 1'b1;
            end else begin
                c_gnt = c_req;
                l_gnt = l_req;
            end
        end
    end

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (c_gnt) begin
            mem_addr  = c_addr;
            mem_wdata = c_wdata;
            mem_we    = c_we;
        end else if (l_gnt) begin
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
            mem_we    = l_we;
        end
    end

    assign c_stall = c_req & ~c_gnt;
    assign c_rdata = mem_rdata;
    assign l_rdata = mem_rdata;
    assign owner   = owner_q;

    // NOTE: synchronous reset inside the clocked block; all state uses non-blocking assignments.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_l     <= 1'b1;
            last_valid <= 1'b0;
            bcnt       <= '0;
            owner_q    <= OWN_NONE;
            c_wait_cnt <= '0;
        end else begin
            if (c_gnt) begin
                last_l     <= 1'b0;
                last_valid <= 1'b1;
                owner_q    <= OWN_CPU;
            end else if (l_gnt) begin
                last_l     <= 1'b1;
                last_valid <= 1'b1;
                owner_q    <= OWN_LDR;
            end

            // Idle cycles, CPU grants and unlocked cycles all end a burst.
            if (c_gnt || !l_gnt || !l_lock)
                bcnt <= '0;
            else if (contested)
                bcnt <= bcnt + 1'b1;

            if (c_stall && (c_wait_cnt != '1))
                c_wait_cnt <= c_wait_cnt + 1'b1;
        end
    end

endmodule
